// File: rtl/pixel_buffer.sv
// First-word-fall-through pixel buffer between the intersect arbiter and the frame-buffer writer.
// Optional `PB_FRAME_DONE_EN adds a drain counter and a registered frame_done pulse.
module pixel_buffer #(
    parameter int DEPTH      = 16,
    parameter int NUM_PIXELS = 307200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pb_we,
    input  logic [42:0]              pb_data,
    output logic                     pb_full,
    output logic [$clog2(DEPTH):0]   pb_count,
    output logic                     fb_valid,
    output logic [42:0]              fb_data,
    input  logic                     fb_stall
`ifdef PB_FRAME_DONE_EN
    ,
    output logic                     frame_done
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [42:0] mem [DEPTH];
    logic        push;
    logic        pop;

    // Flags come from registered pointers only, so no input reaches an output in the same cycle.
    assign pb_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fb_valid = (wptr != rptr);
    assign pb_count = wptr - rptr;
    assign fb_data  = mem[rptr[AW-1:0]];

    assign push = pb_we & ~pb_full;
    assign pop  = fb_valid & ~fb_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is deliberately left uncleared on reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= pb_data;
    end

`ifdef PB_FRAME_DONE_EN
    localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);

    logic [CW-1:0] drain_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && (drain_cnt == LAST);
            if (pop) drain_cnt <= (drain_cnt == LAST) ? '0 : drain_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_buffer.sv
// Scoreboard bench for pixel_buffer: a queue model predicts occupancy and drain order.
// Frame-done checks are built only when PB_FRAME_DONE_EN is defined.
module tb_pixel_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pb_we = 1'b0;
    logic [42:0] pb_data = '0;
    logic        pb_full;
    logic [4:0]  pb_count;
    logic        fb_valid;
    logic [42:0] fb_data;
    logic        fb_stall = 1'b1;
`ifdef PB_FRAME_DONE_EN
    logic        frame_done;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [42:0] sb [$];

    always #5 clk = ~clk;

`ifdef PB_FRAME_DONE_EN
    pixel_buffer #(.DEPTH(DEPTH), .NUM_PIXELS(4)) dut (
        .clk(clk), .rst(rst), .pb_we(pb_we), .pb_data(pb_data), .pb_full(pb_full),
        .pb_count(pb_count), .fb_valid(fb_valid), .fb_data(fb_data), .fb_stall(fb_stall),
        .frame_done(frame_done));
`else
    pixel_buffer #(.DEPTH(DEPTH), .NUM_PIXELS(307200)) dut (
        .clk(clk), .rst(rst), .pb_we(pb_we), .pb_data(pb_data), .pb_full(pb_full),
        .pb_count(pb_count), .fb_valid(fb_valid), .fb_data(fb_data), .fb_stall(fb_stall));
`endif

    function automatic logic [42:0] ent(input int id);
        logic [23:0] c;
        c = 24'(id * 32'h00010203) ^ 24'h5A5A5A;
        return {19'(id), c};
    endfunction

    // Advance one clock; the model pops/pushes from the inputs present at the edge.
    task automatic step();
        bit          do_pop;
        bit          do_push;
        logic [42:0] d;
        logic [42:0] junk;
        do_pop  = (sb.size() != 0) && !fb_stall;
        do_push = pb_we && (sb.size() < DEPTH);
        d       = pb_data;
        @(posedge clk);
        if (do_pop) junk = sb.pop_front();
        if (do_push) sb.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pb_we = 1'b0; fb_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pb_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", pb_count); end
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", fb_valid); end
        vectors++; if (pb_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", pb_full); end
`ifdef PB_FRAME_DONE_EN
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
`endif
        sb.delete();
        rst = 1'b1;
        step();
    endtask

    task automatic test_first_push();
        logic [42:0] exp_d;
        exp_d = {19'h00001, 24'hFFFFFF};
        fb_stall = 1'b1; pb_we = 1'b1; pb_data = exp_d;
        step();
        pb_we = 1'b0;
        vectors++; if (fb_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b want 1", fb_valid); end
        vectors++; if (fb_data !== exp_d) begin miscompares++; $display("FAIL first_data: got %h want %h", fb_data, exp_d); end
        vectors++; if (pb_count !== 5'd1) begin miscompares++; $display("FAIL first_count: got %0d want 1", pb_count); end
        fb_stall = 1'b0;
        vectors++; if (fb_data !== sb[0]) begin miscompares++; $display("FAIL first_pop_data: got %h want %h", fb_data, sb[0]); end
        step();
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL first_empty_valid: got %b want 0", fb_valid); end
        // Stall dropped while empty must not pop anything.
        step();
        vectors++; if (pb_count !== 5'd0) begin miscompares++; $display("FAIL empty_pop_count: got %0d want 0", pb_count); end
    endtask

    task automatic test_fill_full();
        fb_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pb_we = 1'b1; pb_data = ent(i);
            step();
        end
        pb_we = 1'b0;
        vectors++; if (pb_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b want 1", pb_full); end
        vectors++; if (pb_count !== 5'd16) begin miscompares++; $display("FAIL full_count: got %0d want 16", pb_count); end
        pb_we = 1'b1; pb_data = ent(99);
        step();
        pb_we = 1'b0;
        vectors++; if (pb_count !== 5'd16) begin miscompares++; $display("FAIL full_drop_count: got %0d want 16", pb_count); end
        fb_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (fb_valid !== 1'b1) begin miscompares++; $display("FAIL full_drain_valid[%0d]: got %b want 1", i, fb_valid); end
            vectors++; if (fb_data !== ent(i)) begin miscompares++; $display("FAIL full_drain_data[%0d]: got %h want %h", i, fb_data, ent(i)); end
            step();
        end
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL full_drain_empty: got %b want 0", fb_valid); end
    endtask

    task automatic test_full_push_pop();
        fb_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pb_we = 1'b1; pb_data = ent(100 + i);
            step();
        end
        pb_we = 1'b1; pb_data = ent(200); fb_stall = 1'b0;
        vectors++; if (pb_full !== 1'b1) begin miscompares++; $display("FAIL fpp_full_before: got %b want 1", pb_full); end
        vectors++; if (fb_data !== sb[0]) begin miscompares++; $display("FAIL fpp_pop_data: got %h want %h", fb_data, sb[0]); end
        step();
        pb_we = 1'b0; fb_stall = 1'b1;
        vectors++; if (pb_count !== 5'd15) begin miscompares++; $display("FAIL fpp_count: got %0d want 15", pb_count); end
        vectors++; if (pb_full !== 1'b0) begin miscompares++; $display("FAIL fpp_full_after: got %b want 0", pb_full); end
        fb_stall = 1'b0;
        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            vectors++; if (fb_data !== sb[0]) begin miscompares++; $display("FAIL fpp_drain[%0d]: got %h want %h", k, fb_data, sb[0]); end
            step();
        end
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL fpp_drain_empty: got %b want 0", fb_valid); end
    endtask

    task automatic test_back_to_back();
        fb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pb_we = 1'b1; pb_data = ent(300 + i);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            pb_we = 1'b1; pb_data = ent(305 + i); fb_stall = 1'b0;
            vectors++; if (pb_count !== 5'd5) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, pb_count); end
            vectors++; if (fb_data !== ent(300 + i)) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, fb_data, ent(300 + i)); end
            step();
        end
        pb_we = 1'b0;
        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            vectors++; if (fb_data !== sb[0]) begin miscompares++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, fb_data, sb[0]); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        fb_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pb_we = 1'b1; pb_data = ent(400 + i);
            step();
        end
        pb_we = 1'b0;
        vectors++; if (pb_count !== 5'd9) begin miscompares++; $display("FAIL rmid_count_before: got %0d want 9", pb_count); end
        rst = 1'b0;
        #1;
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", fb_valid); end
        vectors++; if (pb_count !== 5'd0) begin miscompares++; $display("FAIL rmid_count: got %0d want 0", pb_count); end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pb_we = 1'b1; pb_data = ent(500);
        step();
        pb_we = 1'b0;
        vectors++; if (fb_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_post_valid: got %b want 1", fb_valid); end
        vectors++; if (fb_data !== ent(500)) begin miscompares++; $display("FAIL rmid_post_data: got %h want %h", fb_data, ent(500)); end
        vectors++; if (pb_count !== 5'd1) begin miscompares++; $display("FAIL rmid_post_count: got %0d want 1", pb_count); end
        fb_stall = 1'b0;
        step();
        vectors++; if (fb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_post_drain: got %b want 0", fb_valid); end
    endtask

`ifdef PB_FRAME_DONE_EN
    task automatic test_frame_done();
        rst = 1'b0; pb_we = 1'b0; fb_stall = 1'b1;
        #2;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pb_we = 1'b1; pb_data = ent(600 + i);
            step();
            vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL fd_fill[%0d]: got %b want 0", i, frame_done); end
        end
        pb_we = 1'b0; fb_stall = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            vectors++; if (fb_data !== ent(599 + k)) begin miscompares++; $display("FAIL fd_data[%0d]: got %h want %h", k, fb_data, ent(599 + k)); end
            step();
            vectors++; if (frame_done !== ((k % 4) == 0)) begin miscompares++; $display("FAIL fd_pulse[%0d]: got %b want %b", k, frame_done, (k % 4) == 0); end
        end
        step();
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL fd_idle: got %b want 0", frame_done); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_push();
        test_fill_full();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
`ifdef PB_FRAME_DONE_EN
        test_frame_done();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
